// File: rtl/seg7_display_ctrl.sv
// Two-digit 7-segment display controller: sequential double-dabble conversion of
// the gated edge count, display holding registers and a time-multiplexed digit bus.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg7_display_ctrl #(
    parameter int COUNT_WIDTH  = 7,
    parameter int MUX_DIV_BITS = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   count_valid,
    output logic                   busy,
    output logic [6:0]             segments,
    output logic                   digit
);

    localparam int STEP_W = $clog2(COUNT_WIDTH + 1);
    localparam logic [STEP_W-1:0]      LAST_STEP = STEP_W'(COUNT_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] MAX_VAL   = COUNT_WIDTH'(99);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [COUNT_WIDTH-1:0]  r_shift;
    logic [7:0]              r_bcd;
    logic [STEP_W-1:0]       r_step;
    logic                    r_ovf_scratch;
    logic                    r_pending;
    logic [COUNT_WIDTH-1:0]  r_pending_val;
    logic [3:0]              r_tens_q;
    logic [3:0]              r_units_q;
    logic                    r_overflow_q;
    logic [MUX_DIV_BITS-1:0] r_div;
    logic                    r_digit;

    logic [7:0]             w_bcd_adj;
    logic [7:0]             w_bcd_shift;
    logic                   w_unused_bcd_msb;
    logic                   w_seed_en;
    logic [COUNT_WIDTH-1:0] w_seed_val;
    logic                   w_pend_set;
    logic [3:0]             w_nibble;
    logic [6:0]             w_seg;

    // Add-3 correction on each BCD nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_bcd_shift      = {w_bcd_adj[6:0], r_shift[COUNT_WIDTH-1]};
    assign w_unused_bcd_msb = w_bcd_adj[7];

    // A new conversion starts from IDLE, or back-to-back out of LOAD; a held
    // pending value always takes precedence over a fresh strobe in LOAD.
    always_comb begin
        w_seed_en  = ((r_state == S_IDLE) && count_valid) ||
                     ((r_state == S_LOAD) && (r_pending || count_valid));
        w_seed_val = ((r_state == S_LOAD) && r_pending) ? r_pending_val : count_in;
        w_pend_set = count_valid &&
                     ((r_state == S_CONVERT) || ((r_state == S_LOAD) && r_pending));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (count_valid) w_state_next = S_CONVERT;
            S_CONVERT: if (r_step == LAST_STEP) w_state_next = S_LOAD;
            S_LOAD:    w_state_next = (r_pending || count_valid) ? S_CONVERT : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_bcd         <= '0;
            r_step        <= '0;
            r_ovf_scratch <= 1'b0;
            r_pending     <= 1'b0;
            r_pending_val <= '0;
            r_tens_q      <= '0;
            r_units_q     <= '0;
            r_overflow_q  <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_tens_q     <= r_bcd[7:4];
                r_units_q    <= r_bcd[3:0];
                r_overflow_q <= r_ovf_scratch;
            end

            if (w_seed_en) begin
                r_shift       <= w_seed_val;
                r_bcd         <= '0;
                r_step        <= '0;
                r_ovf_scratch <= (w_seed_val > MAX_VAL);
            end else if (r_state == S_CONVERT) begin
                r_shift <= r_shift << 1;
                r_bcd   <= w_bcd_shift;
                r_step  <= r_step + 1'b1;
            end

            if (w_pend_set) begin
                r_pending     <= 1'b1;
                r_pending_val <= count_in;
            end else if (r_state == S_LOAD) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_digit <= 1'b0;
        end else begin
            r_div <= r_div + 1'b1;
            if (r_div == '1) begin
                r_digit <= ~r_digit;
            end
        end
    end

    assign digit = r_digit;

    always_comb begin
        w_nibble = r_digit ? r_tens_q : r_units_q;
        case (w_nibble)
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h00;
        endcase
        if (r_overflow_q) begin
            segments = 7'h40;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        end else if (r_digit && (r_tens_q == 4'd0)) begin
            segments = 7'h00;
`endif
        end else begin
            segments = w_seg;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with a 2-bit refresh divider (digit flips every 4 clocks).
module tb_seg7_display_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] count_in;
    logic       count_valid;
    logic       busy;
    logic [6:0] segments;
    logic       digit;

    int total = 0;
    int bad   = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZT = 7'h00;
`else
    localparam logic [6:0] ZT = 7'h3F;
`endif

    seg7_display_ctrl #(
        .COUNT_WIDTH (7),
        .MUX_DIV_BITS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .count_valid(count_valid),
        .busy       (busy),
        .segments   (segments),
        .digit      (digit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [6:0] val);
        count_in    = val;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
    endtask

    // Captures the segment pattern in the tens phase and then the units phase.
    task automatic get_both(output logic [6:0] t, output logic [6:0] u, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (digit !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (digit !== 1'b1) ok = 1'b0;
        t = segments;
        n = 0;
        while (digit !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        if (digit !== 1'b0) ok = 1'b0;
        u = segments;
    endtask

    task automatic test_reset();
        logic [6:0] t, u;
        bit ok;
        reset = 1'b1;
        count_valid = 1'b0;
        count_in = '0;
        repeat (2) tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || digit !== 1'b0 || segments !== 7'h3F) begin
            bad++;
            $display("FAIL reset_state: busy=%b digit=%b seg=%h want busy=0 digit=0 seg=3f", busy, digit, segments);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (digit !== 1'((k / 4) % 2) || busy !== 1'b0) begin
                bad++;
                $display("FAIL mux_toggle k=%0d: digit=%b busy=%b want digit=%0d busy=0", k, digit, busy, (k / 4) % 2);
            end
        end
        get_both(t, u, ok);
        total++;
        if (!ok || t !== ZT || u !== 7'h3F) begin
            bad++;
            $display("FAIL reset_display: tens=%h units=%h ok=%0d want %h/3f", t, u, ok, ZT);
        end
        $display("test_reset: tens=%h units=%h", t, u);
    endtask

    task automatic test_convert_57();
        logic [6:0] t, u;
        bit ok;
        pulse(7'd57);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_57 edge N+%0d: busy=%b want 1", i, busy);
            end
            if (i == 7) begin
                total++;
                if (segments !== (digit ? ZT : 7'h3F)) begin
                    bad++;
                    $display("FAIL early_update_57: seg=%h want old value", segments);
                end
            end
            tick();
        end
        total++;
        if (busy !== 1'b0 || segments !== (digit ? 7'h6D : 7'h07)) begin
            bad++;
            $display("FAIL load_57 N+8: busy=%b seg=%h digit=%b want busy=0 seg=%h", busy, segments, digit, digit ? 7'h6D : 7'h07);
        end
        get_both(t, u, ok);
        total++;
        if (!ok || t !== 7'h6D || u !== 7'h07) begin
            bad++;
            $display("FAIL show_57: tens=%h units=%h want 6d/07", t, u);
        end
        $display("test_convert_57: tens=%h units=%h", t, u);
    endtask

    task automatic test_values();
        logic [6:0] vals [5]  = '{7'd99, 7'd0, 7'd10, 7'd120, 7'd3};
        logic [6:0] exp_t [5] = '{7'h6F, ZT, 7'h06, 7'h40, ZT};
        logic [6:0] exp_u [5] = '{7'h6F, 7'h3F, 7'h3F, 7'h40, 7'h4F};
        logic [6:0] t, u;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            pulse(vals[i]);
            repeat (8) tick();
            get_both(t, u, ok);
            total++;
            if (!ok || t !== exp_t[i] || u !== exp_u[i]) begin
                bad++;
                $display("FAIL value_%0d: tens=%h units=%h want %h/%h", vals[i], t, u, exp_t[i], exp_u[i]);
            end
            $display("test_values: in=%0d tens=%h units=%h", vals[i], t, u);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] t, u;
        bit ok;
        pulse(7'd12);
        repeat (2) tick();
        pulse(7'd34);
        tick();
        pulse(7'd56);
        repeat (3) tick();
        for (int i = 8; i < 16; i++) begin
            total++;
            if (segments !== (digit ? 7'h06 : 7'h5B) || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_hold_12 N+%0d: seg=%h busy=%b want %h busy=1", i, segments, busy, digit ? 7'h06 : 7'h5B);
            end
            tick();
        end
        total++;
        if (segments !== (digit ? 7'h6D : 7'h7D) || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_load_56 N+16: seg=%h busy=%b want %h busy=0", segments, busy, digit ? 7'h6D : 7'h7D);
        end
        repeat (12) tick();
        get_both(t, u, ok);
        total++;
        if (!ok || t !== 7'h6D || u !== 7'h7D) begin
            bad++;
            $display("FAIL b2b_final: tens=%h units=%h want 6d/7d", t, u);
        end
        $display("test_back_to_back: tens=%h units=%h", t, u);
    endtask

    task automatic test_load_strobe();
        logic [6:0] t, u;
        bit ok;
        pulse(7'd42);
        repeat (7) tick();
        pulse(7'd21);
        repeat (7) begin
            total++;
            if (segments !== (digit ? 7'h66 : 7'h5B) || busy !== 1'b1) begin
                bad++;
                $display("FAIL load_strobe_hold: seg=%h busy=%b want %h busy=1", segments, busy, digit ? 7'h66 : 7'h5B);
            end
            tick();
        end
        tick();
        total++;
        if (segments !== (digit ? 7'h5B : 7'h06) || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_strobe_21: seg=%h busy=%b want %h busy=0", segments, busy, digit ? 7'h5B : 7'h06);
        end
        get_both(t, u, ok);
        total++;
        if (!ok || t !== 7'h5B || u !== 7'h06) begin
            bad++;
            $display("FAIL load_strobe_final: tens=%h units=%h want 5b/06", t, u);
        end
        $display("test_load_strobe: tens=%h units=%h", t, u);
    endtask

    task automatic test_reset_mid();
        logic [6:0] t, u;
        bit ok;
        pulse(7'd88);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || digit !== 1'b0 || segments !== 7'h3F) begin
            bad++;
            $display("FAIL reset_mid: busy=%b digit=%b seg=%h want 0/0/3f", busy, digit, segments);
        end
        repeat (10) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: busy=%b want 0", busy);
        end
        get_both(t, u, ok);
        total++;
        if (!ok || t !== ZT || u !== 7'h3F) begin
            bad++;
            $display("FAIL reset_mid_display: tens=%h units=%h want %h/3f", t, u, ZT);
        end
        pulse(7'd64);
        repeat (8) tick();
        get_both(t, u, ok);
        total++;
        if (!ok || t !== 7'h7D || u !== 7'h66) begin
            bad++;
            $display("FAIL reset_mid_next: tens=%h units=%h want 7d/66", t, u);
        end
        $display("test_reset_mid: tens=%h units=%h", t, u);
    endtask

    initial begin
        reset       = 1'b1;
        count_valid = 1'b0;
        count_in    = '0;
        test_reset();
        test_convert_57();
        test_values();
        test_back_to_back();
        test_load_strobe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Downstream stage of the frequency counter core.
- Takes the 7-bit edge count captured at the end of each gate period and converts it to two BCD digits with a sequential shift-add-3 (double dabble).
- Holds the result in display registers and time-multiplexes the digits onto the shared 7-segment bus, driving the digit-select pin.
- Output maps directly to uo_out[6:0] (segments) and uo_out[7] (digit).

Parameters:
- COUNT_WIDTH, 7, width of count_in; max displayable value is 99.
- MUX_DIV_BITS, 10, width of the refresh divider; digit toggles every 2^MUX_DIV_BITS clocks.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- count_in  input  COUNT_WIDTH  count from the frequency counter; valid only with count_valid.
- count_valid  input  1  single-cycle strobe; count_in is sampled on this clock edge.
- busy  output  1  high while a conversion is in progress.
- segments  output  7  active-high segment drive; bit0=a … bit6=g.
- digit  output  1  0 = units digit shown, 1 = tens digit shown.

Behaviour:
- Reset (sync, active-high; dominates all other inputs on the same edge):
  - state=IDLE, busy=0, pending flag=0.
  - tens_q=0, units_q=0, overflow_q=0.
  - Divider=0, digit=0.
  - segments=7'h3F ("0"), since segments is a combinational decode.
- FSM has three states: IDLE, CONVERT, LOAD.
- IDLE:
  - On count_valid: latch count_in into shift register, clear BCD scratch, step counter=0, go to CONVERT.
  - If count_in > 99: set ovf_scratch=1; conversion still runs but its result is discarded.
- CONVERT:
  - One double-dabble iteration per clock: add 3 to any BCD nibble ≥5, then shift left one bit with the binary MSB entering.
  - Exactly COUNT_WIDTH iterations (7 cycles), then go to LOAD.
- LOAD (one cycle):
  - tens_q/units_q ← BCD result; overflow_q ← ovf_scratch.
  - Go to IDLE, or straight to CONVERT (re-seeded from the pending register) if pending=1; clear pending.
- Latency: count_valid sampled on edge N → display registers update on edge N+8 → segments reflect the new value from cycle N+8 onward.
- busy is high from edge N+1 through the LOAD cycle inclusive.
- count_valid while busy: value goes into a one-deep pending register and pending is set. A later strobe overwrites it (newest wins). No strobe is lost except overwritten pendings.
- count_valid in the same cycle as LOAD with pending=0: treated as pending, and conversion begins on the next edge.
- Display mux:
  - Free-running MUX_DIV_BITS divider; digit toggles when the divider wraps to 0.
  - Display registers change independently of the mux phase (no glitch filtering required).
- Segment decode of the selected nibble: 0–9 standard, active-high.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any other nibble value = 00.
- overflow_q=1: both digits show dash (7'h40), regardless of tens_q/units_q.
- Reset mid-conversion: conversion and pending are discarded; display returns to "00".

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: when digit=1, tens_q=0 and overflow_q=0, segments=7'h00 (leading zero blanked).
- Undefined: tens digit always decoded normally ("05" shows as 0 then 5).
- Units digit and dash display are unaffected in both cases.

Test Plan:
- Reset, then idle with MUX_DIV_BITS=2 → segments=3F on both digits; digit toggles every 4 clocks; busy=0.
- count_in=57 with strobe on edge N → busy high N+1..N+8; at N+8 tens_q=5, units_q=7; segments=6D when digit=1, 07 when digit=0.
- count_in=99, then 0, then 10 in separate windows → 6F/6F, then 3F/3F (tens blank, 00, when the macro is defined), then 06/3F.
- count_in=120 → both digits 40. A following count_in=3 → tens 3F (or 00 with macro), units 4F.
- Strobes 12 at N, 34 at N+3, 56 at N+5 → display shows 12 at N+8, then 56 at N+16; 34 is never displayed.
- Reset asserted during CONVERT of 88 → busy=0 next cycle, display 3F/3F, and the next strobe converts normally.
